ssi_sensor_responder: RTL and testbench
=======================================

Name: ssi_sensor_responder

Overview:
- SSI responder that emulates an AS5311-style magnetic position sensor: the slave end of the as5311 clk/cs/do link that `command` drives as master.
- Captures a position/status word when chip-select falls, then shifts it out MSB-first on rising edges of the master's SSI clock.
- Used in Verilator benches and loopback wiring on spare expansion pins, so the reader path can be exercised without physical sensors.

Parameters:
- DATA_BITS, 12, position field width.
- STATUS_BITS, 5, status field width (excluding parity).
- SYNC_STAGES, 2, synchronizer flops on ssi_clk and ssi_cs (minimum 2).
- CNT_BITS, 16, width of frame_count.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- pos  in  DATA_BITS  position value, sampled at frame start.
- status  in  STATUS_BITS  status flags, sampled at frame start.
- ssi_clk  in  1  SSI clock from master, asynchronous, idle high.
- ssi_cs  in  1  chip select from master, asynchronous, active low.
- ssi_do  out  1  serial data to master.
- ssi_do_en  out  1  output enable for the tristate pad; high while selected.
- busy  out  1  high in ARMED or SHIFT.
- frame_done  out  1  1-cycle pulse when a complete frame ends.
- frame_abort  out  1  1-cycle pulse when CS deasserts mid-frame.
- frame_count  out  CNT_BITS  number of completed frames, wraps.

Behaviour:
- Reset values: ssi_do=1, ssi_do_en=0, busy=0, frame_done=0, frame_abort=0, frame_count=0, state IDLE.
- Synchronizer chains reset to 1 (bus idle) for both ssi_clk and ssi_cs.
- Edges are detected on the last sync stage against a registered copy.
- Latency: output update lands SYNC_STAGES+1 clk cycles after the pin edge. Master half-period must be ≥ SYNC_STAGES+2 clk cycles.
- FRAME_BITS = DATA_BITS+STATUS_BITS+1.
- Frame word = {pos, status, parity}, sent MSB first.
- parity = XOR of pos and status bits (even parity: total ones in the frame are even).
- State machine:
  - IDLE: ssi_do_en=0, ssi_do=1.
    - On cs falling: latch the frame word, bit counter=0, go ARMED.
  - ARMED: ssi_do_en=1, ssi_do=1.
    - On ssi_clk rising: drive bit FRAME_BITS-1, counter=1, go SHIFT.
  - SHIFT: on each ssi_clk rising, drive the next lower bit and increment the counter.
    - When counter reaches FRAME_BITS, go DONE; the LSB remains driven until the next rising edge.
  - DONE: on ssi_clk rising, drive ssi_do=0. Extra clocks keep it 0.
- Any state on cs rising: go IDLE; ssi_do_en=0 and ssi_do=1 on the same update.
  - From DONE: frame_done=1 for one cycle and frame_count += 1 (modulo 2^CNT_BITS).
  - From ARMED or SHIFT: frame_abort=1 for one cycle; frame_count unchanged.
- Simultaneous edges in one cycle:
  - cs rising with ssi_clk rising: cs wins, clk edge ignored.
  - cs falling with ssi_clk rising: load only, stay ARMED.
- pos/status changes after capture do not affect the frame in flight.
- Async reset mid-frame: outputs immediately take reset values; no frame_done or frame_abort is generated.

Test Plan:
- pos=0xA5C, status=5'b10010, CS low, 18 clocks, CS high -> ssi_do sequence 1010_0101_1100_10010_0 (parity 0); frame_done pulses once; frame_count=1.
- pos=0x001, status=0 -> sequence 0000_0000_0001_00000_1 (parity 1); ssi_do is 1 in ARMED before the first clock.
- CS low, 7 clocks, CS high -> frame_abort pulses, frame_count unchanged, ssi_do_en=0. The next full frame is correct.
- pos changed 0x123->0xFFF after the 3rd clock -> frame carries 0x123. 20 clocks -> bits 19 and 20 are 0; frame_done still fires.
- cs falling and ssi_clk rising in the same clk cycle (injected after sync) -> state ARMED, no bit consumed. Asserting rst_n low mid-SHIFT -> immediate reset values, no pulses.
- Preload to 0xFFFF via 65535 frames (or by forcing), one more frame -> frame_count=0x0000 and frame_done pulses.

Source files
------------

// File: rtl/ssi_sensor_responder.sv
// SSI responder emulating an AS5311-style position sensor.
// Latches {pos, status, parity} when chip-select falls, then shifts the word
// out MSB-first on rising edges of the master's SSI clock. Both SSI inputs are
// asynchronous and pass through a reset-to-idle synchronizer before edge detection.
module ssi_sensor_responder #(
  parameter int DATA_BITS   = 12,
  parameter int STATUS_BITS = 5,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_BITS    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_BITS-1:0]   pos,
  input  logic [STATUS_BITS-1:0] status,
  input  logic                   ssi_clk,
  input  logic                   ssi_cs,
  output logic                   ssi_do,
  output logic                   ssi_do_en,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   frame_abort,
  output logic [CNT_BITS-1:0]    frame_count
);

  localparam int FRAME_BITS = DATA_BITS + STATUS_BITS + 1;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS + 1);
  localparam logic [BIT_CNT_W-1:0] FRAME_BITS_C = BIT_CNT_W'(FRAME_BITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_SHIFT,
    S_DONE
  } state_t;

  // Synchronizers and edge-detect copies (idle level is 1 on both lines)
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   clk_last_q, clk_last_d;
  logic                   cs_last_q, cs_last_d;

  // Frame state
  state_t                 state_q, state_d;
  logic [FRAME_BITS-1:0]  sh_q, sh_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_inc;
  logic                   do_q, do_d;
  logic                   done_q, done_d;
  logic                   abort_q, abort_d;
  logic [CNT_BITS-1:0]    count_q, count_d;

  logic                   clk_rise;
  logic                   cs_rise;
  logic                   cs_fall;
  logic [FRAME_BITS-1:0]  frame_word;

  // Shift the raw pins into their synchronizer chains; edge detection compares
  // the last stage against a one-cycle-older copy.
  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ssi_clk};
    cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], ssi_cs};
    clk_last_d = clk_sync_q[SYNC_STAGES-1];
    cs_last_d  = cs_sync_q[SYNC_STAGES-1];
  end

  assign clk_rise = clk_sync_q[SYNC_STAGES-1] & ~clk_last_q;
  assign cs_rise  = cs_sync_q[SYNC_STAGES-1] & ~cs_last_q;
  assign cs_fall  = ~cs_sync_q[SYNC_STAGES-1] & cs_last_q;

  // Even parity over the data and status fields makes the whole frame even.
  assign frame_word  = {pos, status, ^{pos, status}};
  assign bit_cnt_inc = bit_cnt_q + 1'b1;

  // Synchronizer registers, reset to the idle bus level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= '1;
      cs_sync_q  <= '1;
      clk_last_q <= 1'b1;
      cs_last_q  <= 1'b1;
    end else begin
      clk_sync_q <= clk_sync_d;
      cs_sync_q  <= cs_sync_d;
      clk_last_q <= clk_last_d;
      cs_last_q  <= cs_last_d;
    end
  end

  // Next-state and output logic; a CS release overrides everything else,
  // including a clock edge that lands in the same cycle.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    do_d      = do_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    count_d   = count_q;

    if (cs_rise) begin
      state_d = S_IDLE;
      do_d    = 1'b1;
      if (state_q == S_DONE) begin
        done_d  = 1'b1;
        count_d = count_q + 1'b1;
      end else if (state_q == S_ARMED || state_q == S_SHIFT) begin
        abort_d = 1'b1;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          // A clock edge coinciding with the CS fall only loads the word.
          if (cs_fall) begin
            sh_d      = frame_word;
            bit_cnt_d = '0;
            do_d      = 1'b1;
            state_d   = S_ARMED;
          end
        end
        S_ARMED: begin
          if (clk_rise) begin
            do_d      = sh_q[FRAME_BITS-1];
            sh_d      = {sh_q[FRAME_BITS-2:0], 1'b0};
            bit_cnt_d = BIT_CNT_W'(1);
            state_d   = S_SHIFT;
          end
        end
        S_SHIFT: begin
          // The LSB stays on the line until the clock edge after it was driven.
          if (clk_rise) begin
            do_d      = sh_q[FRAME_BITS-1];
            sh_d      = {sh_q[FRAME_BITS-2:0], 1'b0};
            bit_cnt_d = bit_cnt_inc;
            if (bit_cnt_inc == FRAME_BITS_C) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (clk_rise) begin
            do_d = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
          do_d    = 1'b1;
        end
      endcase
    end
  end

  // Frame state registers; reset puts the pad in its released, idle-high state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      do_q      <= 1'b1;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      do_q      <= do_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      count_q   <= count_d;
    end
  end

  assign ssi_do      = do_q;
  assign ssi_do_en   = (state_q != S_IDLE);
  assign busy        = (state_q == S_ARMED) || (state_q == S_SHIFT);
  assign frame_done  = done_q;
  assign frame_abort = abort_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_ssi_sensor_responder.sv
// Directed bench for ssi_sensor_responder: acts as the SSI master, collects
// the serial bits and compares them against hand-computed frame words.
module tb_ssi_sensor_responder;

  localparam int HALF = 6;  // master half-period in system clocks

  logic        clk;
  logic        rst_n;
  logic [11:0] pos;
  logic [4:0]  status;
  logic        ssi_clk;
  logic        ssi_cs;
  logic        ssi_do;
  logic        ssi_do_en;
  logic        busy;
  logic        frame_done;
  logic        frame_abort;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;
  int abort_pulses = 0;

  ssi_sensor_responder #(
    .DATA_BITS  (12),
    .STATUS_BITS(5),
    .SYNC_STAGES(2),
    .CNT_BITS   (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pos        (pos),
    .status     (status),
    .ssi_clk    (ssi_clk),
    .ssi_cs     (ssi_cs),
    .ssi_do     (ssi_do),
    .ssi_do_en  (ssi_do_en),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_abort(frame_abort),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done)  done_pulses  <= done_pulses + 1;
    if (frame_abort) abort_pulses <= abort_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_assert();
    ssi_cs = 1'b0;
    wait_cyc(HALF);
  endtask

  task automatic cs_release();
    ssi_cs = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic ssi_pulse(output logic b);
    ssi_clk = 1'b0;
    wait_cyc(HALF);
    ssi_clk = 1'b1;
    wait_cyc(HALF);
    b = ssi_do;
  endtask

  // Runs nclk master clocks with CS low, collecting bits MSB-first.
  // After clock number chg_after, pos is switched to p2.
  task automatic run_frame(input logic [11:0] p, input logic [4:0] s, input int nclk,
                           input int chg_after, input logic [11:0] p2,
                           input string tag, output logic [31:0] bits);
    logic b;
    bits = '0;
    pos = p;
    status = s;
    wait_cyc(1);
    cs_assert();
    check({tag, "_armed_do"}, 32'(ssi_do), 32'd1);
    check({tag, "_armed_en"}, 32'(ssi_do_en), 32'd1);
    for (int i = 0; i < nclk; i++) begin
      ssi_pulse(b);
      bits = {bits[30:0], b};
      if (i + 1 == chg_after) pos = p2;
    end
  endtask

  logic [31:0] bits;
  int d0, a0;

  initial begin
    rst_n = 1'b0;
    pos = '0;
    status = '0;
    ssi_clk = 1'b1;
    ssi_cs = 1'b1;
    wait_cyc(3);
    check("rst_do", 32'(ssi_do), 32'd1);
    check("rst_en", 32'(ssi_do_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_abort", 32'(frame_abort), 32'd0);
    check("rst_count", 32'(frame_count), 32'd0);
    rst_n = 1'b1;
    wait_cyc(4);

    // Frame 1: pos 0xA5C, status 10010, parity 0
    d0 = done_pulses; a0 = abort_pulses;
    run_frame(12'hA5C, 5'b10010, 18, -1, 12'h0, "f1", bits);
    check("f1_word", bits, 32'(18'b1010_0101_1100_10010_0));
    cs_release();
    check("f1_done", 32'(done_pulses - d0), 32'd1);
    check("f1_abort", 32'(abort_pulses - a0), 32'd0);
    check("f1_count", 32'(frame_count), 32'd1);
    check("f1_en_off", 32'(ssi_do_en), 32'd0);

    // Frame 2: pos 0x001, status 0, parity 1
    run_frame(12'h001, 5'b00000, 18, -1, 12'h0, "f2", bits);
    check("f2_word", bits, 32'(18'b0000_0000_0001_00000_1));
    cs_release();
    check("f2_count", 32'(frame_count), 32'd2);

    // Abort after 7 clocks
    d0 = done_pulses; a0 = abort_pulses;
    run_frame(12'hA5C, 5'b10010, 7, -1, 12'h0, "ab", bits);
    check("ab_busy", 32'(busy), 32'd1);
    check("ab_partial", bits, 32'(7'b1010_010));
    cs_release();
    check("ab_abort", 32'(abort_pulses - a0), 32'd1);
    check("ab_done", 32'(done_pulses - d0), 32'd0);
    check("ab_count", 32'(frame_count), 32'd2);
    check("ab_en", 32'(ssi_do_en), 32'd0);
    check("ab_do", 32'(ssi_do), 32'd1);
    check("ab_busy_off", 32'(busy), 32'd0);
    run_frame(12'hA5C, 5'b10010, 18, -1, 12'h0, "af", bits);
    check("af_word", bits, 32'(18'b1010_0101_1100_10010_0));
    cs_release();
    check("af_count", 32'(frame_count), 32'd3);

    // pos changes mid-frame; 20 clocks, trailing bits are 0
    d0 = done_pulses;
    run_frame(12'h123, 5'b00000, 20, 3, 12'hFFF, "pc", bits);
    check("pc_word", bits, 32'({18'b0001_0010_0011_00000_0, 2'b00}));
    cs_release();
    check("pc_done", 32'(done_pulses - d0), 32'd1);
    check("pc_count", 32'(frame_count), 32'd4);

    // CS fall and SSI clock rise arrive in the same cycle
    pos = 12'hA5C;
    status = 5'b10010;
    ssi_clk = 1'b0;
    wait_cyc(HALF);
    ssi_cs = 1'b0;
    ssi_clk = 1'b1;
    wait_cyc(HALF);
    check("sim_busy", 32'(busy), 32'd1);
    check("sim_do", 32'(ssi_do), 32'd1);
    check("sim_state", 32'(dut.state_q), 32'd1);
    begin
      logic b;
      bits = '0;
      for (int i = 0; i < 18; i++) begin
        ssi_pulse(b);
        bits = {bits[30:0], b};
      end
    end
    check("sim_word", bits, 32'(18'b1010_0101_1100_10010_0));
    cs_release();
    check("sim_count", 32'(frame_count), 32'd5);

    // Asynchronous reset in the middle of SHIFT
    d0 = done_pulses; a0 = abort_pulses;
    run_frame(12'h001, 5'b00000, 5, -1, 12'h0, "rs", bits);
    #3 rst_n = 1'b0;
    #1;
    check("rs_do", 32'(ssi_do), 32'd1);
    check("rs_en", 32'(ssi_do_en), 32'd0);
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_count", 32'(frame_count), 32'd0);
    ssi_cs = 1'b1;
    ssi_clk = 1'b1;
    wait_cyc(4);
    rst_n = 1'b1;
    wait_cyc(6);
    check("rs_no_done", 32'(done_pulses - d0), 32'd0);
    check("rs_no_abort", 32'(abort_pulses - a0), 32'd0);
    check("rs_idle_en", 32'(ssi_do_en), 32'd0);

    // Counter wrap from 0xFFFF
    force dut.count_q = 16'hFFFF;
    wait_cyc(2);
    release dut.count_q;
    wait_cyc(2);
    check("wr_pre", 32'(frame_count), 32'h0000FFFF);
    d0 = done_pulses;
    run_frame(12'hA5C, 5'b10010, 18, -1, 12'h0, "wr", bits);
    check("wr_word", bits, 32'(18'b1010_0101_1100_10010_0));
    cs_release();
    check("wr_count", 32'(frame_count), 32'd0);
    check("wr_done", 32'(done_pulses - d0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
